// File: rtl/clk_sup_pkg.sv
// Shared definitions for the clock-generator supervisor: FSM encoding, generator
// configuration defaults and a saturating counter helper.
package clk_sup_pkg;

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StWaitLock = 3'd1;
  localparam logic [2:0] StMeasure  = 3'd2;
  localparam logic [2:0] StRun      = 3'd3;
  localparam logic [2:0] StDcmReset = 3'd4;

  // 1 ms windows at 48 MHz; toggle is the generated clock divided by 2 (12 MHz) or 8 (40 MHz).
  localparam int unsigned GateCycles12 = 48000;
  localparam int unsigned ExpMin12     = 5900;
  localparam int unsigned ExpMax12     = 6100;
  localparam int unsigned GateCycles40 = 48000;
  localparam int unsigned ExpMin40     = 4900;
  localparam int unsigned ExpMax40     = 5100;

  typedef struct packed {
    logic [31:0] gate_cycles;
    logic [31:0] exp_min;
    logic [31:0] exp_max;
  } gen_cfg_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/clk_sup_freq_meter.sv
// Synchronises the monitored-clock toggle and DCM lock, and counts toggle edges over a
// fixed gate window of bus-clock cycles.
module clk_sup_freq_meter
  import clk_sup_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = GateCycles12,
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned EXP_MIN     = ExpMin12,
  parameter int unsigned EXP_MAX     = ExpMax12
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 gate_run_i,
  input  logic                 gate_clr_i,
  input  logic                 toggle_i,
  input  logic                 locked_i,
  output logic                 lock_o,
  output logic                 window_end_o,
  output logic                 in_range_o,
  output logic [CNT_WIDTH-1:0] freq_count_o,
  output logic                 count_valid_o
);

  localparam int unsigned GateW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

  logic [2:0]           tog_q;
  logic [1:0]           lock_q;
  logic [GateW-1:0]     gate_q, gate_d;
  logic [CNT_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_WIDTH-1:0] freq_q, freq_d;
  logic                 valid_q, valid_d;
  logic                 edge_det;
  logic [CNT_WIDTH:0]   sum;
  logic [CNT_WIDTH-1:0] win_cnt;

  assign edge_det     = tog_q[1] ^ tog_q[2];
  assign lock_o       = lock_q[1];
  assign window_end_o = gate_run_i && !gate_clr_i && (gate_q == GateW'(GATE_CYCLES - 1));

  // Running count including this cycle's edge, clamped at all-ones.
  assign sum     = {1'b0, edge_cnt_q} + {{CNT_WIDTH{1'b0}}, edge_det};
  assign win_cnt = sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];

  assign in_range_o = (32'(win_cnt) >= EXP_MIN) && (32'(win_cnt) <= EXP_MAX);

  always_comb begin
    gate_d     = gate_q;
    edge_cnt_d = edge_cnt_q;
    freq_d     = freq_q;
    valid_d    = 1'b0;
    if (!gate_run_i || gate_clr_i) begin
      gate_d     = '0;
      edge_cnt_d = '0;
    end else if (window_end_o) begin
      gate_d     = '0;
      edge_cnt_d = '0;
      freq_d     = win_cnt;
      valid_d    = 1'b1;
    end else begin
      gate_d     = gate_q + GateW'(1);
      edge_cnt_d = win_cnt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tog_q      <= '0;
      lock_q     <= '0;
      gate_q     <= '0;
      edge_cnt_q <= '0;
      freq_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      tog_q      <= {tog_q[1:0], toggle_i};
      lock_q     <= {lock_q[0], locked_i};
      gate_q     <= gate_d;
      edge_cnt_q <= edge_cnt_d;
      freq_q     <= freq_d;
      valid_q    <= valid_d;
    end
  end

  assign freq_count_o  = freq_q;
  assign count_valid_o = valid_q;

endmodule

// File: rtl/clk_gen_supervisor.sv
// Supervises a DCM clock generator: waits for lock, qualifies the generated frequency over
// several windows before releasing downstream reset, and pulses the DCM reset on faults.
module clk_gen_supervisor
  import clk_sup_pkg::*;
#(
  parameter int unsigned GATE_CYCLES    = GateCycles12,
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned EXP_MIN        = ExpMin12,
  parameter int unsigned EXP_MAX        = ExpMax12,
  parameter int unsigned STABLE_WINDOWS = 4,
  parameter int unsigned RST_PULSE      = 16
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST_N,
  input  logic                 ENABLE,
  input  logic                 TOGGLE_IN,
  input  logic                 LOCKED_IN,
  input  logic                 CLEAR_FAULT,
  output logic                 DCM_RST_OUT,
  output logic                 RST_OUT,
  output logic                 FREQ_OK,
  output logic                 FAULT,
  output logic [7:0]           FAULT_CNT,
  output logic [CNT_WIDTH-1:0] FREQ_COUNT,
  output logic                 COUNT_VALID
);

  localparam int unsigned GoodW  = $clog2(STABLE_WINDOWS + 1);
  localparam int unsigned PulseW = $clog2(RST_PULSE + 1);

  logic [2:0]        state_q, state_d;
  logic [GoodW-1:0]  good_q, good_d;
  logic [PulseW-1:0] pulse_q, pulse_d;
  logic              fault_q, fault_d;
  logic [7:0]        fault_cnt_q, fault_cnt_d;
  logic              rst_out_q, dcm_rst_q, freq_ok_q;
  logic              lock, window_end, in_range, gate_run, gate_clr;

  assign gate_run = (state_q != StIdle) && (state_q != StDcmReset);
  assign gate_clr = (state_q == StWaitLock) && lock;

  clk_sup_freq_meter #(
    .GATE_CYCLES (GATE_CYCLES),
    .CNT_WIDTH   (CNT_WIDTH),
    .EXP_MIN     (EXP_MIN),
    .EXP_MAX     (EXP_MAX)
  ) u_freq_meter (
    .clk_i         (BUS_CLK),
    .rst_ni        (BUS_RST_N),
    .gate_run_i    (gate_run),
    .gate_clr_i    (gate_clr),
    .toggle_i      (TOGGLE_IN),
    .locked_i      (LOCKED_IN),
    .lock_o        (lock),
    .window_end_o  (window_end),
    .in_range_o    (in_range),
    .freq_count_o  (FREQ_COUNT),
    .count_valid_o (COUNT_VALID)
  );

  always_comb begin
    state_d     = state_q;
    good_d      = good_q;
    pulse_d     = '0;
    fault_d     = fault_q;
    fault_cnt_d = fault_cnt_q;
    if (!ENABLE) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: state_d = StWaitLock;
        StWaitLock: begin
          if (lock) begin
            state_d = StMeasure;
            good_d  = '0;
          end else if (window_end) begin
            state_d = StDcmReset;
          end
        end
        StMeasure: begin
          // Lock loss wins over a coincident window end.
          if (!lock) begin
            state_d = StDcmReset;
          end else if (window_end) begin
            if (in_range) begin
              good_d = good_q + GoodW'(1);
              if (good_d == GoodW'(STABLE_WINDOWS)) state_d = StRun;
            end else begin
              state_d = StDcmReset;
            end
          end
        end
        StRun: begin
          if (!lock || (window_end && !in_range)) state_d = StDcmReset;
        end
        StDcmReset: begin
          if (pulse_q == PulseW'(RST_PULSE - 1)) state_d = StWaitLock;
          else pulse_d = pulse_q + PulseW'(1);
        end
        default: state_d = StIdle;
      endcase
    end

    if ((state_d == StDcmReset) && (state_q != StDcmReset)) fault_cnt_d = sat_inc8(fault_cnt_q);
    if (CLEAR_FAULT) fault_d = 1'b0;
    if ((state_q == StRun) && (state_d == StDcmReset)) fault_d = 1'b1;
  end

  always_ff @(posedge BUS_CLK) begin
    if (!BUS_RST_N) begin
      state_q     <= StIdle;
      good_q      <= '0;
      pulse_q     <= '0;
      fault_q     <= 1'b0;
      fault_cnt_q <= '0;
      rst_out_q   <= 1'b1;
      dcm_rst_q   <= 1'b0;
      freq_ok_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      good_q      <= good_d;
      pulse_q     <= pulse_d;
      fault_q     <= fault_d;
      fault_cnt_q <= fault_cnt_d;
      rst_out_q   <= (state_d != StRun);
      dcm_rst_q   <= (state_d == StDcmReset);
      freq_ok_q   <= (state_d == StRun);
    end
  end

  assign DCM_RST_OUT = dcm_rst_q;
  assign RST_OUT     = rst_out_q;
  assign FREQ_OK     = freq_ok_q;
  assign FAULT       = fault_q;
  assign FAULT_CNT   = fault_cnt_q;

endmodule

// File: tb/tb_clk_gen_supervisor.sv
// Directed-sequence bench with randomised timing for clk_gen_supervisor; a second
// narrow-counter instance covers edge-count saturation.
`timescale 1ns/1ps
module tb_clk_gen_supervisor;

  localparam int unsigned Gate   = 100;
  localparam int unsigned ExpMin = 20;
  localparam int unsigned ExpMax = 30;
  localparam int unsigned Stable = 4;
  localparam int unsigned Pulse  = 16;

  localparam int WCv   = 0;
  localparam int WOk   = 1;
  localparam int WCv2  = 2;
  localparam int WDcmH = 3;
  localparam int WDcmL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, enable, toggle, locked, clear_fault;
  logic        dcm_rst, rst_out, freq_ok, fault, count_valid;
  logic [7:0]  fault_cnt;
  logic [15:0] freq_count;

  logic        toggle2, en2, lock2, clr2;
  logic        dcm_rst2, rst_out2, freq_ok2, fault2, count_valid2;
  logic [7:0]  fault_cnt2;
  logic [3:0]  freq_count2;

  int vectors = 0;
  int miscompares = 0;
  int tog_period = 4;
  int tog_cnt = 0;
  int cyc = 0;

  clk_gen_supervisor #(
    .GATE_CYCLES(Gate), .CNT_WIDTH(16), .EXP_MIN(ExpMin), .EXP_MAX(ExpMax),
    .STABLE_WINDOWS(Stable), .RST_PULSE(Pulse)
  ) u_dut (
    .BUS_CLK(clk), .BUS_RST_N(rst_n), .ENABLE(enable), .TOGGLE_IN(toggle),
    .LOCKED_IN(locked), .CLEAR_FAULT(clear_fault), .DCM_RST_OUT(dcm_rst), .RST_OUT(rst_out),
    .FREQ_OK(freq_ok), .FAULT(fault), .FAULT_CNT(fault_cnt), .FREQ_COUNT(freq_count),
    .COUNT_VALID(count_valid)
  );

  clk_gen_supervisor #(
    .GATE_CYCLES(Gate), .CNT_WIDTH(4), .EXP_MIN(ExpMin), .EXP_MAX(ExpMax),
    .STABLE_WINDOWS(Stable), .RST_PULSE(Pulse)
  ) u_sat (
    .BUS_CLK(clk), .BUS_RST_N(rst_n), .ENABLE(en2), .TOGGLE_IN(toggle2),
    .LOCKED_IN(lock2), .CLEAR_FAULT(clr2), .DCM_RST_OUT(dcm_rst2), .RST_OUT(rst_out2),
    .FREQ_OK(freq_ok2), .FAULT(fault2), .FAULT_CNT(fault_cnt2), .FREQ_COUNT(freq_count2),
    .COUNT_VALID(count_valid2)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Main toggle source: one toggle every tog_period cycles, held low when 0.
  initial begin
    toggle = 1'b0;
    forever begin
      @(negedge clk);
      if (tog_period == 0) begin
        toggle  = 1'b0;
        tog_cnt = 0;
      end else if (tog_cnt >= tog_period - 1) begin
        toggle  = ~toggle;
        tog_cnt = 0;
      end else begin
        tog_cnt++;
      end
    end
  end

  // Saturation instance: toggles every 2 cycles, 50 edges per window.
  initial begin
    toggle2 = 1'b0;
    forever begin
      @(negedge clk);
      @(negedge clk);
      toggle2 = ~toggle2;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input logic [31:0] obs, input int lo,
                           input int hi);
    vectors++;
    assert ((obs >= lo) && (obs <= hi)) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  function automatic bit sig_now(input int which);
    case (which)
      WCv:     return count_valid === 1'b1;
      WOk:     return freq_ok === 1'b1;
      WCv2:    return count_valid2 === 1'b1;
      WDcmH:   return dcm_rst === 1'b1;
      default: return dcm_rst === 1'b0;
    endcase
  endfunction

  task automatic wait_sig(input int which, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sig_now(which)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_rst_out"}, rst_out, 1);
    check({pfx, "_dcm_rst"}, dcm_rst, 0);
    check({pfx, "_freq_ok"}, freq_ok, 0);
    check({pfx, "_fault"}, fault, 0);
    check({pfx, "_fault_cnt"}, fault_cnt, 0);
    check({pfx, "_freq_count"}, freq_count, 0);
    check({pfx, "_count_valid"}, count_valid, 0);
  endtask

  // Lock drop of one cycle, returning at the negedge the DCM reset is expected to show.
  task automatic drop_lock_one_cycle(input bit clear_with_set);
    locked = 1'b0;
    @(negedge clk);
    locked = 1'b1;
    check("lockdrop_dcm_early1", dcm_rst, 0);
    @(negedge clk);
    check("lockdrop_dcm_early2", dcm_rst, 0);
    clear_fault = clear_with_set;
    @(negedge clk);
    clear_fault = 1'b0;
    check("lockdrop_dcm_rise", dcm_rst, 1);
  endtask

  initial begin
    bit          ok;
    int          n;
    int          p_bad;
    int          t_prev;
    int          bad_tab[4];
    logic [7:0]  m_cnt;
    bit          m_fault;

    bad_tab = '{2, 3, 8, 10};
    m_cnt   = 8'd0;
    m_fault = 1'b0;
    rst_n = 1'b0; enable = 1'b0; locked = 1'b0; clear_fault = 1'b0;
    en2 = 1'b1; lock2 = 1'b1; clr2 = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // Lock arrives, four good windows of 25 edges release the downstream reset.
    rst_n = 1'b1; enable = 1'b1;
    repeat ($urandom_range(60, 5)) @(negedge clk);
    locked = 1'b1;
    for (int w = 0; w < Stable; w++) begin
      wait_sig(WCv, Gate + 20, ok);
      check("t1_cv_seen", ok, 1);
      check("t1_freq_count", freq_count, Gate / 4);
      check("t1_rst_out", rst_out, (w == Stable - 1) ? 0 : 1);
      check("t1_freq_ok", freq_ok, (w == Stable - 1) ? 1 : 0);
      check("t1_dcm_rst", dcm_rst, 0);
    end

    // Stay in RUN, then switch to an out-of-range rate.
    n = $urandom_range(3, 1);
    for (int w = 0; w < n; w++) begin
      wait_sig(WCv, Gate + 20, ok);
      check("t2_cv_seen", ok, 1);
      check("t2_run_count", freq_count, Gate / 4);
      check("t2_run_freq_ok", freq_ok, 1);
      check("t2_run_rst_out", rst_out, 0);
    end
    p_bad = bad_tab[$urandom_range(3, 0)];
    tog_period = p_bad;
    wait_sig(WCv, Gate + 20, ok);
    check("t2_bad_cv_seen", ok, 1);
    check_rng("t2_bad_count", freq_count, Gate / p_bad - 2, Gate / p_bad + 2);
    m_cnt   = m_cnt + 8'd1;
    m_fault = 1'b1;
    check("t2_dcm_rst", dcm_rst, 1);
    check("t2_fault", fault, m_fault);
    check("t2_fault_cnt", fault_cnt, m_cnt);
    check("t2_rst_out", rst_out, 1);
    check("t2_freq_ok", freq_ok, 0);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dcm_rst !== 1'b1) break;
      n++;
    end
    check("t2_pulse_len", n, Pulse);
    tog_period = 4;

    // Back to RUN, clear the fault, then a one-cycle lock loss faults immediately.
    wait_sig(WOk, 8 * Gate, ok);
    check("t4_run_again", ok, 1);
    clear_fault = 1'b1;
    @(negedge clk);
    clear_fault = 1'b0;
    m_fault = 1'b0;
    check("t4_fault_cleared", fault, m_fault);
    wait_sig(WCv, Gate + 20, ok);
    check("t4_cv_seen", ok, 1);
    repeat ($urandom_range(60, 10)) @(negedge clk);
    drop_lock_one_cycle(1'b0);
    m_cnt   = m_cnt + 8'd1;
    m_fault = 1'b1;
    check("t4_fault", fault, m_fault);
    check("t4_fault_cnt", fault_cnt, m_cnt);
    check("t4_rst_out", rst_out, 1);
    wait_sig(WDcmL, Pulse + 4, ok);
    check("t4_pulse_end", ok, 1);

    // Clear coinciding with a fresh RUN fault: the set wins.
    wait_sig(WOk, 8 * Gate, ok);
    check("t4b_run_again", ok, 1);
    clear_fault = 1'b1;
    @(negedge clk);
    clear_fault = 1'b0;
    check("t4b_fault_cleared", fault, 0);
    wait_sig(WCv, Gate + 20, ok);
    check("t4b_cv_seen", ok, 1);
    repeat ($urandom_range(60, 10)) @(negedge clk);
    drop_lock_one_cycle(1'b1);
    m_cnt = m_cnt + 8'd1;
    check("t4b_set_wins", fault, 1);
    check("t4b_fault_cnt", fault_cnt, m_cnt);

    // ENABLE dropped on the fifth pulse cycle truncates the DCM reset.
    repeat (4) @(negedge clk);
    check("t6_pulse_cycle5", dcm_rst, 1);
    enable = 1'b0;
    @(negedge clk);
    check("t6_dcm_truncated", dcm_rst, 0);
    check("t6_rst_out", rst_out, 1);
    check("t6_freq_ok", freq_ok, 0);
    check("t6_fault_kept", fault, 1);
    check("t6_fault_cnt_kept", fault_cnt, m_cnt);
    @(negedge clk);
    enable = 1'b1;
    wait_sig(WOk, 8 * Gate, ok);
    check("t6_run_again", ok, 1);
    tog_period = 0;
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("t6_midrun_reset");
    repeat (3) @(negedge clk);
    m_cnt = 8'd0;

    // Static toggle gives a zero count; the 4-bit instance saturates at 15.
    rst_n = 1'b1;
    wait_sig(WCv, 2 * Gate, ok);
    check("t5_cv_seen", ok, 1);
    check("t5_static_count", freq_count, 0);
    m_cnt = m_cnt + 8'd1;
    check("t5_dcm_rst", dcm_rst, 1);
    check("t5_fault", fault, 0);
    check("t5_fault_cnt", fault_cnt, m_cnt);
    for (int k = 0; k < 2; k++) begin
      wait_sig(WCv2, 3 * Gate, ok);
      check("t5_sat_cv_seen", ok, 1);
      check("t5_sat_count", freq_count2, 15);
    end

    // No lock ever: periodic DCM resets, FAULT never set, FAULT_CNT saturates.
    rst_n = 1'b0; locked = 1'b0; tog_period = 4;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_cnt  = 8'd0;
    t_prev = 0;
    for (int k = 1; k <= 260; k++) begin
      wait_sig(WDcmH, Gate + Pulse + 40, ok);
      check("t3_dcm_rise", ok, 1);
      if (!ok) break;
      m_cnt = (m_cnt == 8'hff) ? m_cnt : m_cnt + 8'd1;
      check("t3_fault_cnt", fault_cnt, m_cnt);
      check("t3_fault", fault, 0);
      if (k > 1) check("t3_interval", cyc - t_prev, Gate + Pulse);
      t_prev = cyc;
      wait_sig(WDcmL, Pulse + 4, ok);
      check("t3_pulse_end", ok, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clk_gen_supervisor.md
Name: clk_gen_supervisor

Overview:
- Supervises a DCM-based clock generator from the bus domain, on the receiving end of the generator's outputs.
- Measures the frequency of a generated clock from a toggle signal driven in that clock's domain.
- Monitors the DCM LOCKED output, requests DCM resets on fault, and releases the downstream reset only after lock plus N consecutive in-range measurements.
- Sits beside the clock generator in the MIO top level; its outputs gate the FE command/data logic.

Parameters:
GATE_CYCLES, 48000, measurement window length in BUS_CLK cycles (1 ms at 48 MHz)
CNT_WIDTH, 16, width of edge counter and FREQ_COUNT
EXP_MIN, 5900, minimum accepted edge count per window
EXP_MAX, 6100, maximum accepted edge count per window
STABLE_WINDOWS, 4, consecutive good windows needed before release (>=1)
RST_PULSE, 16, DCM_RST_OUT assertion length in BUS_CLK cycles (>=1)

Ports:
BUS_CLK  in  1  bus clock; sole clock
BUS_RST_N  in  1  synchronous active-low reset
ENABLE  in  1  supervisor enable
TOGGLE_IN  in  1  async; toggles once per monitored-clock event; rate <= BUS_CLK/4
LOCKED_IN  in  1  async DCM LOCKED
CLEAR_FAULT  in  1  single-cycle clear of sticky FAULT
DCM_RST_OUT  out  1  DCM reset request, active high
RST_OUT  out  1  downstream reset, active high
FREQ_OK  out  1  high only in RUN
FAULT  out  1  sticky fault flag
FAULT_CNT  out  8  saturating count of DCM_RESET entries
FREQ_COUNT  out  CNT_WIDTH  last completed window's edge count
COUNT_VALID  out  1  one-cycle pulse when FREQ_COUNT updates

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-low (BUS_CLK, BUS_RST_N).
- Reset values: RST_OUT=1, DCM_RST_OUT=0, FREQ_OK=0, FAULT=0, FAULT_CNT=0, FREQ_COUNT=0, COUNT_VALID=0, state=IDLE, all counters 0.
- Synchronisers:
  - TOGGLE_IN: 3-FF chain; edge = ff2 XOR ff3.
  - LOCKED_IN: 2-FF; lock = ff2.
- Gate counter:
  - Counts 0..GATE_CYCLES-1 in every state except IDLE and DCM_RESET, where it is held at 0.
  - The window covers edges detected in cycles 0..GATE_CYCLES-1 inclusive.
  - At the terminal cycle: FREQ_COUNT <= edge_cnt + edge, saturated to all-ones; COUNT_VALID=1 for the next cycle; edge_cnt <= 0.
  - edge_cnt saturates and never wraps.
- in_range = EXP_MIN <= window count <= EXP_MAX, both inclusive.
- FSM states: IDLE, WAIT_LOCK, MEASURE, RUN, DCM_RESET.
  - IDLE: RST_OUT=1. ENABLE=1 -> WAIT_LOCK.
  - WAIT_LOCK: lock=1 -> MEASURE with good_cnt=0 and the gate restarted. A full window ending with lock=0 -> DCM_RESET.
  - MEASURE:
    - Window end and in_range: good_cnt++; when good_cnt reaches STABLE_WINDOWS -> RUN.
    - Window end and out of range -> DCM_RESET.
    - lock=0 -> DCM_RESET immediately.
  - RUN: RST_OUT=0 and FREQ_OK=1, both registered and effective the cycle after entry. An out-of-range window or lock=0 -> DCM_RESET.
  - DCM_RESET: DCM_RST_OUT=1 for exactly RST_PULSE cycles, RST_OUT=1, then -> WAIT_LOCK.
- ENABLE=0 in any state -> IDLE next cycle.
  - An in-progress DCM_RST_OUT pulse is truncated.
  - FAULT and FAULT_CNT are retained.
- Fault bookkeeping:
  - Every DCM_RESET entry increments FAULT_CNT, saturating at 255.
  - Entry from RUN also sets FAULT.
  - CLEAR_FAULT clears FAULT; if it coincides with a set, the set wins.
- Simultaneous lock loss and window end: lock loss takes precedence. Outcome is the same (DCM_RESET) with a single FAULT_CNT increment.
- BUS_RST_N low mid-operation: all registers return to reset values on the next edge, including truncation of a DCM_RST_OUT pulse.

Decomposition:
- Shared package clk_sup_pkg:
  - FSM state encoding constants (IDLE=0 .. DCM_RESET=4).
  - Default GATE_CYCLES/EXP_MIN/EXP_MAX for the 12 MHz and 40 MHz generator configurations.
- One natural sub-module: clk_sup_freq_meter. It contains the synchronisers, edge detect, gate counter, edge counter, FREQ_COUNT and COUNT_VALID, and exports window_end and in_range.
- The top level holds the FSM, pulse timer and fault logic.

Test Plan:
1. GATE_CYCLES=100, EXP_MIN=20, EXP_MAX=30, STABLE_WINDOWS=4. TOGGLE_IN toggles every 4 cycles; LOCKED_IN=1 from cycle 10 -> every COUNT_VALID shows FREQ_COUNT 25±1; RST_OUT falls after 4 good windows; FREQ_OK=1.
2. Same setup, in RUN: toggle period changes to 2 cycles (50 edges) -> at that window end, DCM_RESET; DCM_RST_OUT high exactly 16 cycles; FAULT=1; FAULT_CNT=1; RST_OUT=1.
3. LOCKED_IN held 0 after enable -> DCM_RESET after every 100-cycle window plus 16-cycle pulse; FAULT stays 0; FAULT_CNT saturates at 255 and does not wrap.
4. In RUN, drop LOCKED_IN for 1 cycle (after sync delay) -> immediate DCM_RESET, no wait for window end. Then CLEAR_FAULT asserted in the same cycle as a new RUN fault -> FAULT remains 1.
5. TOGGLE_IN static -> FREQ_COUNT=0; continuous toggling with CNT_WIDTH=4 and a 100-cycle window -> FREQ_COUNT=15 (saturated).
6. ENABLE dropped on cycle 5 of a DCM_RST_OUT pulse -> DCM_RST_OUT=0 next cycle, state IDLE, FAULT_CNT retained. BUS_RST_N low in RUN -> all outputs at reset values next cycle.
